sweep_ctrl: RTL and testbench
=============================

// Module: sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the sine generator datapath. It drives that
//  datapath's en and incr inputs and steps the phase increment from f_start
//  toward f_stop by f_step. Each increment value is held for dwell+1 cycles.
//  Sits between the config/stimulus logic and the sine generator; handshakes
//  via start/busy/done/abort.
// PARAMETERS
//  D_WIDTH  8   width of frequency/increment values (matches sinegen incr)
//  DW_WIDTH 16  width of dwell counter/config
// PORTS
//  clk      in  1         system clock, rising edge
//  rst      in  1         async reset, ACTIVE-LOW (0 = reset)
//  start    in  1         begin sweep; sampled only in IDLE
//  abort    in  1         terminate sweep; priority over start
//  f_start  in  D_WIDTH   first increment value
//  f_stop   in  D_WIDTH   last allowed increment value (inclusive)
//  f_step   in  D_WIDTH   increment added per dwell period
//  dwell    in  DW_WIDTH  hold length minus 1 (0 -> 1 cycle per value)
//  en_o     out 1         enable to sine generator address counter
//  incr_o   out D_WIDTH   increment to sine generator
//  busy     out 1         high in RUN
//  done     out 1         1-cycle pulse on normal sweep completion
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE; en_o=0, incr_o=0, busy=0, done=0,
//    internal counters=0. All outputs are registered.
//  - States: IDLE, RUN, DONE.
//  - IDLE: en_o=0, incr_o=0, busy=0.
//    - start=1 & abort=0 at edge: latch f_start/f_stop/f_step/dwell; go RUN.
//    - At the same edge: incr_o<=f_start, en_o<=1, busy<=1, dwell_cnt<=0.
//    - Latency start->en_o high = 1 cycle.
//  - RUN: en_o=1. The config inputs are not re-sampled, so they may change
//    freely during RUN.
//    - dwell_cnt != dwell_lat: dwell_cnt++.
//    - dwell_cnt == dwell_lat: nxt = incr_o + step_lat, computed in
//      D_WIDTH+1 bits (no wrap).
//      - If step_lat==0 or nxt > stop_lat: go DONE; en_o<=0, busy<=0,
//        done<=1.
//      - Otherwise: incr_o<=nxt[D_WIDTH-1:0], dwell_cnt<=0.
//    - start is ignored in RUN.
//  - DONE: one cycle only; done=1, en_o=0; incr_o holds the last value.
//    Then IDLE, where done<=0 and incr_o<=0.
//  - abort=1 in RUN or DONE: next state IDLE.
//    - en_o<=0, busy<=0, incr_o<=0.
//    - done is not pulsed; if DONE is already showing done=1, it clears.
//  - abort=1 in IDLE: start is blocked.
//  - Boundary cases:
//    - f_start>f_stop: f_start is held for one dwell, then DONE.
//    - f_step=0: a single dwell at f_start, then DONE.
//    - An increment that would overshoot f_stop or exceed 2^D_WIDTH-1 is
//      never emitted.
//  - Values emitted: f_start + k*f_step for k=0..K, where K is the largest k
//    giving a value <= f_stop. Total en_o-high cycles = (K+1)*(dwell+1).
//  - rst asserted mid-sweep: outputs go to 0 immediately (async).
//    - On release, the FSM idles until the next start.
// TESTING
//  T1 start, f_start=4, f_stop=10, f_step=3, dwell=1
//     -> en_o high 6 cycles, incr_o 4,4,7,7,10,10.
//     -> Then done=1 for 1 cycle, busy=0.
//  T2 f_start=4, f_stop=9, f_step=3, dwell=0
//     -> incr_o 4,7 (2 cycles), then done; 10 never appears.
//  T3 f_start=250, f_stop=255, f_step=4, dwell=0
//     -> incr_o 250,254, then done; no wrap to 2.
//  T4 f_step=0 (and separately f_start=20 > f_stop=5), dwell=2
//     -> 3 cycles of incr_o=f_start, then done.
//  T5 abort during the 2nd value of T1
//     -> next cycle en_o=0, incr_o=0, busy=0; done stays 0.
//     -> A start during RUN has no effect.
//  T6 rst=0 pulsed mid-sweep, between clock edges
//     -> outputs 0 before the next edge; after release, idle until start.

Source files
------------

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - frequency-sweep sequencer driving a sine generator's en/incr
//
// Steps the generator increment from f_start toward f_stop by f_step.
// Each value is held for dwell+1 cycles.
// Ports:
//   clk, rst       clock (rising edge), async active-low reset
//   start, abort   sweep control; abort has priority over start
//   f_start/f_stop/f_step/dwell
//                  sweep configuration, latched when a sweep starts
//   en_o, incr_o   enable and increment to the sine generator
//   busy, done     busy while running; done is a 1-cycle completion pulse
module sweep_ctrl #(
   parameter int D_WIDTH  = 8,
   parameter int DW_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [D_WIDTH-1:0]  f_start,
   input  logic [D_WIDTH-1:0]  f_stop,
   input  logic [D_WIDTH-1:0]  f_step,
   input  logic [DW_WIDTH-1:0] dwell,
   output logic                en_o,
   output logic [D_WIDTH-1:0]  incr_o,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                en_q, en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [D_WIDTH-1:0]  incr_q, incr_d;
   logic [D_WIDTH-1:0]  stop_q, stop_d;
   logic [D_WIDTH-1:0]  step_q, step_d;
   logic [DW_WIDTH-1:0] dwell_q, dwell_d;
   logic [DW_WIDTH-1:0] cnt_q, cnt_d;

   // Next increment is formed one bit wider so a carry out of the top bit
   // reads as "beyond f_stop" instead of wrapping to a small value.
   logic [D_WIDTH:0] nxt_w;
   logic             dwell_end_w;
   logic             last_w;

   assign nxt_w       = {1'b0, incr_q} + {1'b0, step_q};
   assign dwell_end_w = (cnt_q == dwell_q);
   assign last_w      = (step_q == '0) || (nxt_w > {1'b0, stop_q});

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         incr_q  <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         incr_q  <= incr_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start && !abort) state_d = S_RUN;
         S_RUN: begin
            if (abort)                      state_d = S_IDLE;
            else if (dwell_end_w && last_w) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, counters and latched config
   always_comb begin
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = done_q;
      incr_d  = incr_q;
      stop_d  = stop_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            en_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b0;
            incr_d = '0;
            if (start && !abort) begin
               stop_d  = f_stop;
               step_d  = f_step;
               dwell_d = dwell;
               incr_d  = f_start;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               en_d   = 1'b0;
               busy_d = 1'b0;
               done_d = 1'b0;
               incr_d = '0;
            end else if (!dwell_end_w) begin
               cnt_d = cnt_q + 1'b1;
            end else if (last_w) begin
               // Last value stays on incr_o through the DONE cycle
               en_d   = 1'b0;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               incr_d = nxt_w[D_WIDTH-1:0];
               cnt_d  = '0;
            end
         end
         default: begin
            // DONE (with or without abort) always returns to an idle output set
            en_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b0;
            incr_d = '0;
         end
      endcase
   end

   assign en_o   = en_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign incr_o = incr_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - directed bench for sweep_ctrl
module tb_sweep_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [7:0]  f_start;
   logic [7:0]  f_stop;
   logic [7:0]  f_step;
   logic [15:0] dwell;
   logic        en_o;
   logic [7:0]  incr_o;
   logic        busy;
   logic        done;

   int n_cmp;
   int n_bad;
   int exp_q[$];

   sweep_ctrl #(.D_WIDTH(8), .DW_WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .f_start (f_start),
      .f_stop  (f_stop),
      .f_step  (f_step),
      .dwell   (dwell),
      .en_o    (en_o),
      .incr_o  (incr_o),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int e_en, input int e_incr,
                            input int e_busy, input int e_done);
      check({tag, ".en"},   int'(en_o),   e_en);
      check({tag, ".incr"}, int'(incr_o), e_incr);
      check({tag, ".busy"}, int'(busy),   e_busy);
      check({tag, ".done"}, int'(done),   e_done);
   endtask

   // Runs one full sweep; exp_q holds the distinct values expected on incr_o.
   // Config inputs are scrambled after the start edge to show they are latched.
   task automatic sweep(input string tag, input int fs, input int fe,
                        input int st, input int dw);
      int last;
      f_start = 8'(fs);
      f_stop  = 8'(fe);
      f_step  = 8'(st);
      dwell   = 16'(dw);
      start   = 1'b1;
      last    = 0;
      foreach (exp_q[k]) begin
         for (int r = 0; r <= dw; r++) begin
            @(negedge clk);
            start   = 1'b0;
            f_start = 8'd0;
            f_stop  = 8'd0;
            f_step  = 8'd1;
            dwell   = 16'd0;
            check_out($sformatf("%s.v%0d.r%0d", tag, k, r), 1, exp_q[k], 1, 0);
            last = exp_q[k];
         end
      end
      @(negedge clk);
      check_out({tag, ".done"}, 0, last, 0, 1);
      @(negedge clk);
      check_out({tag, ".idle"}, 0, 0, 0, 0);
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst     = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      f_start = 8'd0;
      f_stop  = 8'd0;
      f_step  = 8'd0;
      dwell   = 16'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check_out("reset", 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      check_out("post_reset", 0, 0, 0, 0);

      // T1: 4,4,7,7,10,10 then done
      exp_q = '{4, 7, 10};
      sweep("t1", 4, 10, 3, 1);

      // T2: 10 overshoots f_stop=9
      exp_q = '{4, 7};
      sweep("t2", 4, 9, 3, 0);

      // T3: 258 would wrap to 2 in 8 bits
      exp_q = '{250, 254};
      sweep("t3", 250, 255, 4, 0);

      // T4: zero step, and f_start above f_stop
      exp_q = '{20};
      sweep("t4a", 20, 30, 0, 2);
      exp_q = '{20};
      sweep("t4b", 20, 5, 3, 2);

      // T5: start ignored in RUN, abort during the 2nd value
      f_start = 8'd4; f_stop = 8'd10; f_step = 8'd3; dwell = 16'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_out("t5.c0", 1, 4, 1, 0);
      @(negedge clk);
      check_out("t5.c1", 1, 4, 1, 0);
      start = 1'b1;
      @(negedge clk);
      check_out("t5.c2_start_ignored", 1, 7, 1, 0);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      check_out("t5.abort", 0, 0, 0, 0);
      abort = 1'b0;
      @(negedge clk);
      check_out("t5.idle", 0, 0, 0, 0);

      // abort blocks start in IDLE
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check_out("abort_blocks_start", 0, 0, 0, 0);
      abort = 1'b0;
      start = 1'b0;

      // T6: async reset mid-sweep, between edges
      f_start = 8'd4; f_stop = 8'd10; f_step = 8'd3; dwell = 16'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_out("t6.running", 1, 4, 1, 0);
      #2 rst = 1'b0;
      #1 check_out("t6.async", 0, 0, 0, 0);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_out("t6.idle_after", 0, 0, 0, 0);

      // sweep works again after reset
      exp_q = '{4, 7};
      sweep("t6.restart", 4, 9, 3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
